ddr3_ref_arb: RTL and testbench

Command-port arbiter and refresh scheduler between the DDR3 configurator, the memory-controller FSM and the DDL. It owns the single DDL command channel. Before `cfg_run_i` it passes configurator commands straight through. Afterwards it grants the channel to the controller FSM, keeps a count of owed REFRESH commands from the configurator's tREFI tick, and inserts PRECHARGE-ALL plus REFRESH at burst boundaries, forcing them when the debt becomes urgent.

---
 rtl/ddr3_ref_arb.sv | 164 ++++++++++++++++
 tb/tb_ddr3_ref_arb.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_ref_arb.sv
// ddr3_ref_arb: owns the single DDL command channel.
// Before cfg_run_i the configurator is passed straight through to the DDL.
// Afterwards the controller FSM is granted the channel, while owed REFRESH
// commands (from the tREFI tick) are counted and inserted as PRECHARGE-ALL +
// REFRESH pairs at burst boundaries, forced once the debt becomes urgent.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   cfg_run_i                    initialisation complete (level)
//   cfg_req/cmd/ba/adr_i, cfg_rdy_o          configurator command port
//   cfg_ref_i                    one-cycle tREFI tick
//   fsm_req/seq/cmd/ba/adr_i, fsm_rdy_o      controller command port
//   fsm_ref_o                    refresh pending, FSM should close its rows
//   ddl_req/seq/cmd/ba/adr_o, ddl_rdy_i      command to the DDL
//   ref_ovf_o                    sticky: tick dropped at maximum debt
module ddr3_ref_arb #(
  parameter int unsigned DDR_ROW_BITS = 13,
  parameter int unsigned REF_POSTPONE = 8,
  parameter int unsigned REF_URGENT   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cfg_run_i,
  input  logic                    cfg_req_i,
  input  logic [2:0]              cfg_cmd_i,
  input  logic [2:0]              cfg_ba_i,
  input  logic [DDR_ROW_BITS-1:0] cfg_adr_i,
  output logic                    cfg_rdy_o,
  input  logic                    cfg_ref_i,
  input  logic                    fsm_req_i,
  input  logic                    fsm_seq_i,
  input  logic [2:0]              fsm_cmd_i,
  input  logic [2:0]              fsm_ba_i,
  input  logic [DDR_ROW_BITS-1:0] fsm_adr_i,
  output logic                    fsm_rdy_o,
  output logic                    fsm_ref_o,
  output logic                    ddl_req_o,
  output logic                    ddl_seq_o,
  output logic [2:0]              ddl_cmd_o,
  output logic [2:0]              ddl_ba_o,
  output logic [DDR_ROW_BITS-1:0] ddl_adr_o,
  input  logic                    ddl_rdy_i,
  output logic                    ref_ovf_o
);

  localparam int unsigned RSB = DDR_ROW_BITS - 1;
  localparam int unsigned DW  = $clog2(REF_POSTPONE + 1);

  localparam logic [2:0]   CMD_NOOP = 3'b111;
  localparam logic [2:0]   CMD_PREC = 3'b010;
  localparam logic [2:0]   CMD_REFR = 3'b001;
  localparam logic [RSB:0] ADR_A10  = DDR_ROW_BITS'(32'h400);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_FSM  = 2'd1,
    ST_PREA = 2'd2,
    ST_REFR = 2'd3
  } state_t;

  state_t        state_q;
  logic [DW-1:0] debt_q, debt_d;
  logic          burst_q;
  logic          ovf_q, ovf_d;

  logic tick;
  logic refr_xfer;
  logic fsm_xfer;
  logic boundary;
  logic urgent;

  assign tick      = cfg_ref_i && cfg_run_i;
  assign refr_xfer = (state_q == ST_REFR) && ddl_rdy_i;
  assign fsm_xfer  = fsm_req_i && fsm_rdy_o;
  assign boundary  = !burst_q && !fsm_req_i;
  // Urgent debt blocks the FSM as soon as no burst is open, even if it is requesting.
  assign urgent    = !burst_q && (debt_q >= DW'(REF_URGENT));

  // Refresh debt: tick and REFR transfer in the same cycle cancel out.
  always_comb begin
    debt_d = debt_q;
    ovf_d  = ovf_q;
    if (tick && !refr_xfer) begin
      if (debt_q == DW'(REF_POSTPONE)) ovf_d = 1'b1;
      else                             debt_d = debt_q + DW'(1);
    end else if (refr_xfer && !tick) begin
      debt_d = debt_q - DW'(1);
    end
  end

  // Command mux selected by the registered state; no latency on the granted path.
  always_comb begin
    ddl_req_o = 1'b0;
    ddl_seq_o = 1'b0;
    ddl_cmd_o = CMD_NOOP;
    ddl_ba_o  = 3'b000;
    ddl_adr_o = '0;
    cfg_rdy_o = 1'b0;
    fsm_rdy_o = 1'b0;
    case (state_q)
      ST_INIT: begin
        ddl_req_o = cfg_req_i;
        ddl_cmd_o = cfg_cmd_i;
        ddl_ba_o  = cfg_ba_i;
        ddl_adr_o = cfg_adr_i;
        cfg_rdy_o = ddl_rdy_i;
      end
      ST_FSM: begin
        // A blocked FSM must not reach the DDL, so its req is gated too.
        ddl_req_o = fsm_req_i && !urgent;
        ddl_seq_o = fsm_seq_i;
        ddl_cmd_o = fsm_cmd_i;
        ddl_ba_o  = fsm_ba_i;
        ddl_adr_o = fsm_adr_i;
        fsm_rdy_o = ddl_rdy_i && !urgent;
      end
      ST_PREA: begin
        ddl_req_o = 1'b1;
        ddl_seq_o = 1'b1;
        ddl_cmd_o = CMD_PREC;
        ddl_adr_o = ADR_A10;
      end
      ST_REFR: begin
        ddl_req_o = 1'b1;
        ddl_cmd_o = CMD_REFR;
      end
      default: ;
    endcase
  end

  assign fsm_ref_o = (debt_q != '0) || (state_q == ST_PREA) || (state_q == ST_REFR);
  assign ref_ovf_o = ovf_q;

  // State, burst tracking and debt registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      debt_q  <= '0;
      burst_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
      if (fsm_xfer) burst_q <= fsm_seq_i;
      case (state_q)
        ST_INIT: if (cfg_run_i && !cfg_req_i) state_q <= ST_FSM;
        ST_FSM: begin
          if (!cfg_run_i && boundary)                      state_q <= ST_INIT;
          else if ((boundary && debt_q != '0) || urgent)   state_q <= ST_PREA;
        end
        ST_PREA: if (ddl_rdy_i) state_q <= ST_REFR;
        ST_REFR: begin
          // Keep refreshing back-to-back while the remaining debt is still urgent.
          if (ddl_rdy_i) begin
            if (!cfg_run_i)                         state_q <= ST_INIT;
            else if (debt_d >= DW'(REF_URGENT))     state_q <= ST_PREA;
            else                                    state_q <= ST_FSM;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_ref_arb.sv
// Testbench for ddr3_ref_arb: directed scenarios followed by a randomized run,
// checked against a transaction-level model of the refresh debt and the
// PRECHARGE-ALL/REFRESH insertion rules.
module tb_ddr3_ref_arb;

  localparam logic [19:0] X_PREC = {3'b010, 3'b000, 13'h0400, 1'b1};
  localparam logic [19:0] X_REFR = {3'b001, 3'b000, 13'h0000, 1'b0};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_run = 1'b0;
  logic        cfg_req = 1'b0;
  logic [2:0]  cfg_cmd = 3'b111;
  logic [2:0]  cfg_ba = 3'b000;
  logic [12:0] cfg_adr = '0;
  logic        cfg_rdy;
  logic        cfg_ref = 1'b0;
  logic        fsm_req = 1'b0;
  logic        fsm_seq = 1'b0;
  logic [2:0]  fsm_cmd = 3'b111;
  logic [2:0]  fsm_ba = 3'b000;
  logic [12:0] fsm_adr = '0;
  logic        fsm_rdy;
  logic        fsm_ref;
  logic        ddl_req;
  logic        ddl_seq;
  logic [2:0]  ddl_cmd;
  logic [2:0]  ddl_ba;
  logic [12:0] ddl_adr;
  logic        ddl_rdy = 1'b0;
  logic        ref_ovf;
  logic [19:0] ddl_x;

  int total = 0;
  int bad   = 0;

  assign ddl_x = {ddl_cmd, ddl_ba, ddl_adr, ddl_seq};

  always #5 clock = ~clock;

  ddr3_ref_arb dut (
    .clock     (clock),
    .reset     (reset),
    .cfg_run_i (cfg_run),
    .cfg_req_i (cfg_req),
    .cfg_cmd_i (cfg_cmd),
    .cfg_ba_i  (cfg_ba),
    .cfg_adr_i (cfg_adr),
    .cfg_rdy_o (cfg_rdy),
    .cfg_ref_i (cfg_ref),
    .fsm_req_i (fsm_req),
    .fsm_seq_i (fsm_seq),
    .fsm_cmd_i (fsm_cmd),
    .fsm_ba_i  (fsm_ba),
    .fsm_adr_i (fsm_adr),
    .fsm_rdy_o (fsm_rdy),
    .fsm_ref_o (fsm_ref),
    .ddl_req_o (ddl_req),
    .ddl_seq_o (ddl_seq),
    .ddl_cmd_o (ddl_cmd),
    .ddl_ba_o  (ddl_ba),
    .ddl_adr_o (ddl_adr),
    .ddl_rdy_i (ddl_rdy),
    .ref_ovf_o (ref_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference model: debt = accepted ticks - REFRESH transfers, capped at 8.
  int          mdebt = 0;
  bit          movf = 0;
  bit          mburst = 0;
  bit          mexp_refr = 0;
  int          n_tick = 0;
  int          n_refr = 0;
  logic [19:0] xq[$];

  initial forever begin
    logic fx, cx, inj, tk, rf;
    @(negedge clock);
    fx  = fsm_req && fsm_rdy;
    cx  = cfg_req && cfg_rdy;
    inj = ddl_req && ddl_rdy && !fx && !cx;
    chk("debt", 32'(dut.debt_q), mdebt);
    chk("ovf", ref_ovf, movf);
    chk("fsm_ref", fsm_ref, mdebt != 0);
    if (mdebt >= 4 && !mburst) chk("urgent_block", fsm_rdy, 0);
    if (fsm_rdy) begin
      chk("grant_req", ddl_req, fsm_req);
      if (fsm_req) chk("grant_cmd", ddl_x, {fsm_cmd, fsm_ba, fsm_adr, fsm_seq});
    end
    if (ddl_req && ddl_rdy) xq.push_back(ddl_x);
    rf = inj && mexp_refr;
    if (inj) begin
      if (!mexp_refr) begin
        chk("prec_cmd", ddl_x, X_PREC);
        chk("prec_in_burst", mburst, 0);
      end else begin
        chk("refr_cmd", ddl_x, X_REFR);
      end
      mexp_refr = !mexp_refr;
    end
    tk = cfg_ref && cfg_run;
    if (reset) begin
      mdebt = 0; movf = 0; mburst = 0; mexp_refr = 0;
    end else begin
      if (fx) mburst = fsm_seq;
      if (rf) n_refr++;
      if (tk && rf) n_tick++;
      else if (tk) begin
        if (mdebt == 8) movf = 1;
        else begin mdebt++; n_tick++; end
      end else if (rf) mdebt--;
    end
  end

  task automatic fsm_send(input logic [2:0] c, input logic [2:0] b, input logic [12:0] a,
                          input logic s, output int blocked);
    bit done;
    blocked = 0;
    done = 0;
    fsm_req = 1'b1; fsm_cmd = c; fsm_ba = b; fsm_adr = a; fsm_seq = s;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (fsm_rdy) done = 1;
      else blocked++;
      step();
    end
    chk("fsm_send_accept", done, 1);
  endtask

  logic [19:0] want_log[8];
  int          blk;
  bit          done;
  bit          acc;
  bit          open;

  initial begin
    // Reset values
    cfg_req = 1'b1;
    step(); step();
    chk("rst_debt", 32'(dut.debt_q), 0);
    chk("rst_ovf", ref_ovf, 0);
    chk("rst_fsm_rdy", fsm_rdy, 0);
    chk("rst_fsm_ref", fsm_ref, 0);
    chk("rst_ddl_req", ddl_req, 1);
    reset = 1'b0;

    // Init passthrough with a junk FSM request that must not leak through
    fsm_req = 1'b1; fsm_cmd = 3'b100;
    for (int k = 0; k < 5; k++) begin
      cfg_req = 1'b1;
      cfg_cmd = 3'($urandom); cfg_ba = 3'($urandom); cfg_adr = 13'($urandom);
      done = 0;
      for (int c = 0; c < 8 && !done; c++) begin
        ddl_rdy = ~ddl_rdy;
        #1;
        chk("init_pass", {ddl_req, ddl_x}, {1'b1, cfg_cmd, cfg_ba, cfg_adr, 1'b0});
        chk("init_cfg_rdy", cfg_rdy, ddl_rdy);
        chk("init_fsm_rdy", fsm_rdy, 0);
        done = ddl_rdy;
        step();
      end
      chk("init_accept", done, 1);
    end
    cfg_req = 1'b0; fsm_req = 1'b0; ddl_rdy = 1'b1;
    #1 chk("init_idle_req", ddl_req, 0);
    step();

    // Run: controller owns the channel, configurator is locked out
    cfg_run = 1'b1;
    step();
    cfg_req = 1'b1;
    #1;
    chk("run_cfg_rdy", cfg_rdy, 0);
    chk("run_ddl_req", ddl_req, 0);
    cfg_req = 1'b0;

    // Idle refresh
    cfg_ref = 1'b1;
    step();
    cfg_ref = 1'b0;
    #1;
    chk("idle_ref_pend", fsm_ref, 1);
    chk("idle_no_req", ddl_req, 0);
    step();
    chk("idle_prec", {ddl_req, ddl_x}, {1'b1, X_PREC});
    step();
    chk("idle_refr", {ddl_req, ddl_x}, {1'b1, X_REFR});
    step();
    chk("idle_ref_drop", fsm_ref, 0);
    chk("idle_debt", 32'(dut.debt_q), 0);

    // Burst protection and urgent block
    xq.delete();
    fsm_send(3'b011, 3'd3, 13'h123, 1'b1, blk);
    chk("act_blocked", blk, 0);
    fsm_req = 1'b1; fsm_cmd = 3'b100; fsm_adr = 13'h124; fsm_seq = 1'b1;
    ddl_rdy = 1'b0; cfg_ref = 1'b1;
    repeat (5) step();
    cfg_ref = 1'b0; ddl_rdy = 1'b1;
    chk("burst_debt5", 32'(dut.debt_q), 5);
    fsm_send(3'b100, 3'd3, 13'h124, 1'b1, blk);
    chk("wr1_blocked", blk, 0);
    fsm_send(3'b100, 3'd3, 13'h125, 1'b0, blk);
    chk("wr0_blocked", blk, 0);
    fsm_send(3'b101, 3'd3, 13'h126, 1'b0, blk);
    chk("urgent_wait", blk, 5);
    chk("after_rd_debt", 32'(dut.debt_q), 3);
    fsm_req = 1'b0;
    want_log[0] = {3'b011, 3'd3, 13'h123, 1'b1};
    want_log[1] = {3'b100, 3'd3, 13'h124, 1'b1};
    want_log[2] = {3'b100, 3'd3, 13'h125, 1'b0};
    want_log[3] = X_PREC;
    want_log[4] = X_REFR;
    want_log[5] = X_PREC;
    want_log[6] = X_REFR;
    want_log[7] = {3'b101, 3'd3, 13'h126, 1'b0};
    chk("log_size", xq.size(), 8);
    for (int i = 0; i < 8 && i < xq.size(); i++) chk($sformatf("log_%0d", i), xq[i], want_log[i]);
    for (int i = 0; i < 40 && fsm_ref; i++) step();
    chk("drain_ref", fsm_ref, 0);
    chk("drain_debt", 32'(dut.debt_q), 0);

    // Saturation
    ddl_rdy = 1'b0; cfg_ref = 1'b1;
    repeat (9) step();
    cfg_ref = 1'b0;
    #1;
    chk("sat_debt", 32'(dut.debt_q), 8);
    chk("sat_ovf", ref_ovf, 1);
    chk("sat_prec_held", {ddl_req, ddl_x}, {1'b1, X_PREC});
    ddl_rdy = 1'b1;
    step();
    ddl_rdy = 1'b0;
    #1 chk("sat_in_refr", ddl_cmd, 3'b001);
    cfg_ref = 1'b1; ddl_rdy = 1'b1;
    step();
    cfg_ref = 1'b0; ddl_rdy = 1'b0;
    #1;
    chk("sat_same_cycle", 32'(dut.debt_q), 8);
    chk("sat_ovf_sticky", ref_ovf, 1);

    // Reset in the middle of a REFRESH
    ddl_rdy = 1'b1;
    step();
    ddl_rdy = 1'b0;
    #1 chk("mid_in_refr", ddl_cmd, 3'b001);
    cfg_req = 1'b1; cfg_cmd = 3'b111; reset = 1'b1;
    step();
    chk("mid_rst_debt", 32'(dut.debt_q), 0);
    chk("mid_rst_ovf", ref_ovf, 0);
    chk("mid_rst_fsm_ref", fsm_ref, 0);
    chk("mid_rst_fsm_rdy", fsm_rdy, 0);
    chk("mid_rst_pass", ddl_req, 1);
    reset = 1'b0; cfg_req = 1'b0;
    step();

    // Randomized traffic
    n_tick = 0; n_refr = 0; xq.delete();
    acc = 0; open = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!fsm_req || acc) begin
        if (acc && fsm_seq) fsm_req = 1'b1;
        else fsm_req = ($urandom_range(0, 2) == 0);
        case ($urandom_range(0, 2))
          0:       fsm_cmd = 3'b011;
          1:       fsm_cmd = 3'b100;
          default: fsm_cmd = 3'b101;
        endcase
        fsm_ba = 3'($urandom); fsm_adr = 13'($urandom);
        fsm_seq = ($urandom_range(0, 2) == 0);
      end
      cfg_ref = ($urandom_range(0, 9) == 0);
      ddl_rdy = ($urandom_range(0, 3) != 0);
      cfg_req = 1'($urandom);
      #1;
      chk("rand_cfg_rdy", cfg_rdy, 0);
      acc = fsm_req && fsm_rdy;
      if (acc) open = fsm_seq;
      step();
    end
    cfg_ref = 1'b0; cfg_req = 1'b0; ddl_rdy = 1'b1;
    if (fsm_req && !acc) begin
      fsm_send(fsm_cmd, fsm_ba, fsm_adr, fsm_seq, blk);
      open = fsm_seq;
    end
    if (open) fsm_send(3'b101, 3'd0, 13'h0, 1'b0, blk);
    fsm_req = 1'b0;
    for (int i = 0; i < 60 && fsm_ref; i++) step();
    chk("rand_drain_ref", fsm_ref, 0);
    chk("rand_debt0", 32'(dut.debt_q), 0);
    chk("rand_ref_count", n_refr, n_tick);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
